kronos_xif_dispatcher: RTL



---
 rtl/kronos_xif_dispatcher.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/kronos_xif_dispatcher.sv
// XIF front-end for KRONOS: claims custom-0 instructions, parks them per engine slot
// until commit/kill, dispatches to the engine and returns results through a FIFO.
module kronos_xif_dispatcher #(
    parameter int unsigned NUM_UNITS      = 2,
    parameter int unsigned X_ID_WIDTH     = 4,
    parameter int unsigned XLEN           = 32,
    parameter int unsigned RES_FIFO_DEPTH = 4,
    parameter logic [6:0]  KRONOS_OPCODE  = 7'h0B
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      issue_valid_i,
    output logic                      issue_ready_o,
    input  logic [31:0]               issue_instr_i,
    input  logic [X_ID_WIDTH-1:0]     issue_id_i,
    input  logic [XLEN-1:0]           issue_rs1_i,
    input  logic [XLEN-1:0]           issue_rs2_i,
    output logic                      issue_accept_o,
    output logic                      issue_writeback_o,
    input  logic                      commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]     commit_id_i,
    input  logic                      commit_kill_i,
    output logic [NUM_UNITS-1:0]      unit_req_valid_o,
    input  logic [NUM_UNITS-1:0]      unit_req_ready_i,
    output logic [NUM_UNITS*32-1:0]   unit_req_instr_o,
    output logic [NUM_UNITS*XLEN-1:0] unit_req_rs1_o,
    output logic [NUM_UNITS*XLEN-1:0] unit_req_rs2_o,
    input  logic [NUM_UNITS-1:0]      unit_rsp_valid_i,
    output logic [NUM_UNITS-1:0]      unit_rsp_ready_o,
    input  logic [NUM_UNITS*XLEN-1:0] unit_rsp_data_i,
    output logic                      result_valid_o,
    input  logic                      result_ready_i,
    output logic [X_ID_WIDTH-1:0]     result_id_o,
    output logic [4:0]                result_rd_o,
    output logic [XLEN-1:0]           result_data_o,
    output logic                      result_we_o,
    output logic                      busy_o
);

    localparam int unsigned UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int unsigned FW = $clog2(RES_FIFO_DEPTH);
    localparam int unsigned CW = $clog2(RES_FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_COMMIT, S_DISPATCH, S_RUN} slot_state_e;

    slot_state_e           r_state     [NUM_UNITS];
    slot_state_e           w_state_nxt [NUM_UNITS];
    logic [X_ID_WIDTH-1:0] r_id        [NUM_UNITS];
    logic [31:0]           r_instr     [NUM_UNITS];
    logic [XLEN-1:0]       r_rs1       [NUM_UNITS];
    logic [XLEN-1:0]       r_rs2       [NUM_UNITS];
    logic [4:0]            r_rd        [NUM_UNITS];
    logic [UW-1:0]         r_rr;

    logic [X_ID_WIDTH-1:0] r_fifo_id   [RES_FIFO_DEPTH];
    logic [4:0]            r_fifo_rd   [RES_FIFO_DEPTH];
    logic [XLEN-1:0]       r_fifo_data [RES_FIFO_DEPTH];
    logic [FW-1:0]         r_wptr, r_rptr;
    logic [CW-1:0]         r_count;

    logic                  w_match, w_issue_fire, w_commit_new;
    logic                  w_grant_found, w_rsp_found;
    logic [UW-1:0]         w_grant_idx, w_scan_idx;
    logic [NUM_UNITS-1:0]  w_idle, w_run, w_rsp_ready, w_rsp_fire;
    logic                  w_full, w_push, w_pop;
    logic [X_ID_WIDTH-1:0] w_push_id;
    logic [4:0]            w_push_rd;
    logic [XLEN-1:0]       w_push_data;

    always_comb begin
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            w_idle[i] = (r_state[i] == S_IDLE);
            w_run[i]  = (r_state[i] == S_RUN);
        end
    end

    assign w_match           = (issue_instr_i[6:0] == KRONOS_OPCODE);
    assign issue_ready_o     = w_match ? (|w_idle) : 1'b1;
    assign issue_accept_o    = w_match;
    assign issue_writeback_o = w_match;
    assign w_issue_fire      = issue_valid_i && w_match && (|w_idle);
    assign w_commit_new      = commit_valid_i && (commit_id_i == issue_id_i);

    // Round-robin slot grant: first IDLE slot scanning upward from r_rr with wrap.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_scan_idx    = '0;
        for (int unsigned k = 0; k < NUM_UNITS; k++) begin
            w_scan_idx = UW'((32'(r_rr) + k) % NUM_UNITS);
            if (!w_grant_found && w_idle[w_scan_idx]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_scan_idx;
            end
        end
    end

    always_comb begin
        w_rsp_found = 1'b0;
        w_rsp_ready = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (!w_rsp_found && w_run[i] && unit_rsp_valid_i[i]) begin
                w_rsp_found    = 1'b1;
                w_rsp_ready[i] = !w_full;
            end
        end
    end

    assign w_rsp_fire       = w_rsp_ready & unit_rsp_valid_i;
    assign w_push           = |w_rsp_fire;
    assign unit_rsp_ready_o = w_rsp_ready;

    always_comb begin
        w_push_id   = '0;
        w_push_rd   = '0;
        w_push_data = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (w_rsp_fire[i]) begin
                w_push_id   = r_id[i];
                w_push_rd   = r_rd[i];
                w_push_data = unit_rsp_data_i[i*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                S_IDLE: begin
                    // A commit arriving alongside its own issue resolves the new slot at once.
                    if (w_issue_fire && (w_grant_idx == UW'(i))) begin
                        if (w_commit_new) w_state_nxt[i] = commit_kill_i ? S_IDLE : S_DISPATCH;
                        else              w_state_nxt[i] = S_WAIT_COMMIT;
                    end
                end
                S_WAIT_COMMIT: begin
                    if (commit_valid_i && (commit_id_i == r_id[i]))
                        w_state_nxt[i] = commit_kill_i ? S_IDLE : S_DISPATCH;
                end
                S_DISPATCH: if (unit_req_ready_i[i]) w_state_nxt[i] = S_RUN;
                S_RUN:      if (w_rsp_fire[i])       w_state_nxt[i] = S_IDLE;
                default:    w_state_nxt[i] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NUM_UNITS; i++) r_state[i] <= S_IDLE;
        end else begin
            for (int unsigned i = 0; i < NUM_UNITS; i++) r_state[i] <= w_state_nxt[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr <= '0;
            for (int unsigned i = 0; i < NUM_UNITS; i++) begin
                r_id[i]    <= '0;
                r_instr[i] <= '0;
                r_rs1[i]   <= '0;
                r_rs2[i]   <= '0;
                r_rd[i]    <= '0;
            end
        end else if (w_issue_fire) begin
            r_rr <= (w_grant_idx == UW'(NUM_UNITS - 1)) ? '0 : w_grant_idx + 1'b1;
            for (int unsigned i = 0; i < NUM_UNITS; i++) begin
                if (w_grant_idx == UW'(i)) begin
                    r_id[i]    <= issue_id_i;
                    r_instr[i] <= issue_instr_i;
                    r_rs1[i]   <= issue_rs1_i;
                    r_rs2[i]   <= issue_rs2_i;
                    r_rd[i]    <= issue_instr_i[11:7];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            unit_req_valid_o[i]                = (r_state[i] == S_DISPATCH);
            unit_req_instr_o[i*32 +: 32]       = r_instr[i];
            unit_req_rs1_o[i*XLEN +: XLEN]     = r_rs1[i];
            unit_req_rs2_o[i*XLEN +: XLEN]     = r_rs2[i];
        end
    end

    assign w_full         = (r_count == CW'(RES_FIFO_DEPTH));
    assign result_valid_o = (r_count != '0);
    assign w_pop          = result_valid_o && result_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < RES_FIFO_DEPTH; i++) begin
                r_fifo_id[i]   <= '0;
                r_fifo_rd[i]   <= '0;
                r_fifo_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo_id[r_wptr]   <= w_push_id;
                r_fifo_rd[r_wptr]   <= w_push_rd;
                r_fifo_data[r_wptr] <= w_push_data;
                r_wptr <= (r_wptr == FW'(RES_FIFO_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop)
                r_rptr <= (r_rptr == FW'(RES_FIFO_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign result_id_o   = r_fifo_id[r_rptr];
    assign result_rd_o   = r_fifo_rd[r_rptr];
    assign result_data_o = r_fifo_data[r_rptr];
    assign result_we_o   = (result_rd_o != 5'd0);
    assign busy_o        = (~&w_idle) || result_valid_o;

endmodule
